// File: rtl/shift_reg_sequencer.sv
// Round-robin front end for two word requesters that drives an external
// parallel-in shift register and streams each accepted word out MSB first.
module shift_reg_sequencer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic             Q_msb,
   output logic             mode,
   output logic [WIDTH-1:0] paralelIn,
   output logic             SerialIn,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             word_done,
   output logic             grant_id,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_ptr;
   logic [WIDTH-1:0]  r_hold;
   logic              r_grant;
   logic              r_mode;
   logic              r_sv;
   logic              r_wd;
   logic              r_busy;

   logic              w_window;
   logic              w_ready0;
   logic              w_ready1;
   logic              w_accept;
   logic              w_win;
   logic [WIDTH-1:0]  w_data;

   // Accept window and round-robin arbitration; ptr = 1 favours requester 1.
   always_comb begin
      w_window = !RST && ((r_state == S_IDLE) ||
                          ((r_state == S_SHIFT) && (r_cnt == LAST)));
      w_ready0 = w_window && req0_valid && (!req1_valid || !r_ptr);
      w_ready1 = w_window && req1_valid && (!req0_valid ||  r_ptr);
      w_accept = w_ready0 || w_ready1;
      w_win    = w_ready1;
      w_data   = w_ready1 ? req1_data : req0_data;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= 1'b0;
         r_hold  <= '0;
         r_grant <= 1'b0;
         r_mode  <= 1'b1;
         r_sv    <= 1'b0;
         r_wd    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_LOAD;
                  r_mode  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               r_state <= S_SHIFT;
               r_cnt   <= '0;
               r_mode  <= 1'b1;
               r_sv    <= 1'b1;
               r_wd    <= (LAST == '0);
            end
            S_SHIFT: begin
               r_cnt <= r_cnt + CW'(1);
               r_wd  <= (r_cnt == PRE_LAST);
               // Last bit: either chain straight into the next LOAD or go idle.
               if (r_cnt == LAST) begin
                  r_cnt <= '0;
                  r_sv  <= 1'b0;
                  r_wd  <= 1'b0;
                  if (w_accept) begin
                     r_state <= S_LOAD;
                     r_mode  <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_mode  <= 1'b1;
               r_sv    <= 1'b0;
               r_wd    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase

         if (w_accept) begin
            r_hold  <= w_data;
            r_grant <= w_win;
            r_ptr   <= !w_win;
         end
      end
   end

   assign req0_ready   = w_ready0;
   assign req1_ready   = w_ready1;
   assign mode         = r_mode;
   assign paralelIn    = r_hold;
   assign SerialIn     = 1'b0;
   assign serial_valid = r_sv;
   assign serial_out   = r_sv & Q_msb;
   assign word_done    = r_wd;
   assign grant_id     = r_grant;
   assign busy         = r_busy;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: external shift register model, cycle-age
// reference model with word scoreboard, directed cases and random traffic.
module tb_shift_reg_sequencer;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         req0_valid = 1'b0;
   logic [W-1:0] req0_data  = '0;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req1_data  = '0;
   logic         req0_ready, req1_ready;
   logic         Q_msb;
   logic         mode;
   logic [W-1:0] paralelIn;
   logic         SerialIn, serial_out, serial_valid, word_done, grant_id, busy;

   shift_reg_sequencer #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .Q_msb(Q_msb), .mode(mode), .paralelIn(paralelIn), .SerialIn(SerialIn),
      .serial_out(serial_out), .serial_valid(serial_valid),
      .word_done(word_done), .grant_id(grant_id), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // The controlled parallel-in shift register.
   logic [W-1:0] q_sr = '0;
   always @(posedge CLK) q_sr <= mode ? {q_sr[W-2:0], SerialIn} : paralelIn;
   assign Q_msb = q_sr[W-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: m_age = -1 idle, 0 load cycle, 1..W bit cycles of a word.
   int           m_age = -1;
   bit           m_ptr = 1'b0;
   bit           m_grant = 1'b0;
   logic [W-1:0] m_hold = '0;
   bit           e_win, e_r0, e_r1, e_sv, e_so;

   logic [W-1:0] sb_q[$];
   int           acc_q[$];
   logic [W-1:0] shw = '0;
   logic [W-1:0] sb_exp;
   int           nb = 0, first_c = 0, cyc = 0, wait0 = 0, wait1 = 0, a_c;

   logic [W-1:0] lg_word[$];
   bit           lg_id[$];
   int           lg_acc[$], lg_first[$], lg_done[$];

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (RST) begin
         chk("rst_ready0", 32'(req0_ready), 0);
         chk("rst_ready1", 32'(req1_ready), 0);
         chk("rst_mode", 32'(mode), 1);
         chk("rst_paralelIn", 32'(paralelIn), 0);
         chk("rst_serial_valid", 32'(serial_valid), 0);
         chk("rst_word_done", 32'(word_done), 0);
         chk("rst_grant_id", 32'(grant_id), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_serial_out", 32'(serial_out), 0);
         m_age = -1; m_ptr = 1'b0; m_grant = 1'b0; m_hold = '0;
         sb_q.delete(); acc_q.delete();
         nb = 0; wait0 = 0; wait1 = 0;
      end else begin
         e_win = (m_age < 0) || (m_age == W);
         e_r0  = e_win && req0_valid && (!req1_valid || !m_ptr);
         e_r1  = e_win && req1_valid && (!req0_valid ||  m_ptr);
         e_sv  = (m_age >= 1);
         e_so  = 1'b0;
         if (m_age >= 1) e_so = m_hold[W - m_age];
         chk("ready0", 32'(req0_ready), 32'(e_r0));
         chk("ready1", 32'(req1_ready), 32'(e_r1));
         chk("ready_both", 32'(req0_ready && req1_ready), 0);
         chk("mode", 32'(mode), 32'(m_age != 0));
         chk("paralelIn", 32'(paralelIn), 32'(m_hold));
         chk("serial_valid", 32'(serial_valid), 32'(e_sv));
         chk("serial_out", 32'(serial_out), 32'(e_so));
         chk("word_done", 32'(word_done), 32'(m_age == W));
         chk("grant_id", 32'(grant_id), 32'(m_grant));
         chk("busy", 32'(busy), 32'(m_age >= 0));
         chk("SerialIn", 32'(SerialIn), 0);

         // Scoreboard driven by the DUT's own handshake and serial stream.
         if (serial_valid) begin
            shw = {shw[W-2:0], serial_out};
            nb++;
            if (nb == 1) first_c = cyc;
         end
         if (word_done) begin
            chk("sb_pending", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               sb_exp = sb_q.pop_front();
               a_c    = acc_q.pop_front();
               chk("sb_word", 32'(shw), 32'(sb_exp));
               chk("sb_bits", 32'(nb), 32'(W));
               lg_word.push_back(shw); lg_id.push_back(grant_id);
               lg_acc.push_back(a_c); lg_first.push_back(first_c); lg_done.push_back(cyc);
            end
            nb = 0;
         end
         if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
            sb_q.push_back((req1_ready && req1_valid) ? req1_data : req0_data);
            acc_q.push_back(cyc);
            if (req0_ready && req0_valid) wait0 = 0; else if (req0_valid) wait0++; else wait0 = 0;
            if (req1_ready && req1_valid) wait1 = 0; else if (req1_valid) wait1++; else wait1 = 0;
            chk("starve0", 32'(wait0 <= 1), 1);
            chk("starve1", 32'(wait1 <= 1), 1);
         end

         if (e_r0 || e_r1) begin
            m_hold  = e_r1 ? req1_data : req0_data;
            m_grant = e_r1;
            m_ptr   = !e_r1;
            m_age   = 0;
         end else if (m_age == W) m_age = -1;
         else if (m_age >= 0) m_age++;
      end
   end

   task automatic reset_dut(input int n);
      @(posedge CLK); #2 RST = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (n) @(negedge CLK);
      @(posedge CLK); #1 RST = 1'b0;
   endtask

   task automatic wait_log(input int target);
      int k = 0;
      while (lg_word.size() < target && k < 100) begin @(negedge CLK); k++; end
      chk("wait_log", 32'(lg_word.size() >= target), 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge CLK);
      while (busy && k < 60) begin @(negedge CLK); k++; end
      chk("wait_idle", 32'(busy), 0);
   endtask

   task automatic send_one(input bit id, input logic [W-1:0] d);
      @(posedge CLK); #1;
      if (id) begin req1_valid = 1'b1; req1_data = d; end
      else    begin req0_valid = 1'b1; req0_data = d; end
      @(negedge CLK);
      chk("send_ready", 32'(id ? req1_ready : req0_ready), 1);
      @(posedge CLK); #1 req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      int n, k;
      reset_dut(3);

      // Single word 1001 from requester 0.
      n = lg_word.size();
      send_one(1'b0, 4'b1001);
      @(negedge CLK);
      chk("t1_load_mode", 32'(mode), 0);
      chk("t1_load_par", 32'(paralelIn), 32'(4'b1001));
      wait_log(n + 1);
      if (lg_word.size() > n) begin
         chk("t1_word", 32'(lg_word[n]), 32'(4'b1001));
         chk("t1_id", 32'(lg_id[n]), 0);
         chk("t1_latency", 32'(lg_first[n] - lg_acc[n]), 2);
         chk("t1_span", 32'(lg_done[n] - lg_first[n]), 3);
      end
      wait_idle();

      // Both valid from reset: 1100 then 0011 with one LOAD cycle between.
      reset_dut(2);
      n = lg_word.size();
      @(posedge CLK); #1;
      req0_valid = 1'b1; req0_data = 4'b1100;
      req1_valid = 1'b1; req1_data = 4'b0011;
      k = 0;
      do begin @(negedge CLK); k++; end while (!req1_ready && k < 40);
      chk("t2_ready1_seen", 32'(req1_ready), 1);
      @(posedge CLK); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_log(n + 2);
      if (lg_word.size() > n + 1) begin
         chk("t2_word0", 32'(lg_word[n]), 32'(4'b1100));
         chk("t2_id0", 32'(lg_id[n]), 0);
         chk("t2_word1", 32'(lg_word[n+1]), 32'(4'b0011));
         chk("t2_id1", 32'(lg_id[n+1]), 1);
         chk("t2_gap", 32'(lg_first[n+1] - lg_done[n]), 2);
      end
      wait_idle();

      // Requester 1 continuously valid: one word every WIDTH+1 cycles.
      n = lg_word.size();
      @(posedge CLK); #1 req1_valid = 1'b1; req1_data = 4'b0110;
      wait_log(n + 3);
      @(posedge CLK); #1 req1_valid = 1'b0;
      if (lg_word.size() > n + 2) begin
         chk("t3_period_a", 32'(lg_done[n+1] - lg_done[n]), 5);
         chk("t3_period_b", 32'(lg_done[n+2] - lg_done[n+1]), 5);
         chk("t3_id", 32'(lg_id[n+2]), 1);
         chk("t3_word", 32'(lg_word[n+1]), 32'(4'b0110));
      end
      wait_idle();

      // Reset during the second bit of 1010 aborts the word.
      n = lg_word.size();
      send_one(1'b0, 4'b1010);
      k = 0;
      do begin @(negedge CLK); k++; end while (!serial_valid && k < 10);
      chk("t4_first_bit", 32'(serial_out), 1);
      @(posedge CLK); #2 RST = 1'b1;
      #1;
      chk("t4_sv_async", 32'(serial_valid), 0);
      chk("t4_wd_async", 32'(word_done), 0);
      chk("t4_busy_async", 32'(busy), 0);
      @(negedge CLK);
      @(posedge CLK); #1 RST = 1'b0;
      repeat (8) @(negedge CLK);
      chk("t4_no_resend", 32'(lg_word.size()), 32'(n));
      send_one(1'b0, 4'b0110);
      wait_log(n + 1);
      if (lg_word.size() > n) chk("t4_next_word", 32'(lg_word[n]), 32'(4'b0110));
      wait_idle();

      // Random traffic on both ports.
      n = lg_word.size();
      for (int i = 0; i < 2000; i++) begin
         @(posedge CLK); #1;
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_data  = W'($urandom);
         req1_data  = W'($urandom);
      end
      @(posedge CLK); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      chk("rnd_sb_empty", 32'(sb_q.size()), 0);
      chk("rnd_words", 32'(lg_word.size() > n + 200), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
